wb_xact_controller: RTL

- Registered, sequential replacement for the combinational Wishbone interconnect in nebula_ii.
- Decodes each Caravel Wishbone transaction to one target: a team design, LA control or GPIO control.
- Strobes the selected target, waits for its ack under a timeout, and returns a registered ack and data to the master.
- Allows one outstanding transaction. A hung or unmapped target can never stall the management core.

---
 rtl/wb_xact_controller_pkg.sv | 43 ++++
 rtl/wb_xact_controller_if.sv | 19 +
 rtl/wb_target_mux.sv | 49 ++++
 rtl/wb_xact_controller.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/wb_xact_controller_pkg.sv
// rtl/wb_xact_controller_pkg.sv - shared types, constants and decode for the Wishbone transaction controller
package wb_xact_controller_pkg;

    localparam logic [7:0]  LA_SEL   = 8'h70;
    localparam logic [7:0]  GPIO_SEL = 8'h80;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_TEAM,
        TGT_LA,
        TGT_GPIO
    } tgt_kind_t;

    typedef struct packed {
        tgt_kind_t  kind;
        logic [7:0] team;
    } tgt_sel_t;

    // Team indices take precedence should a select value collide with LA/GPIO.
    function automatic tgt_sel_t decode_sel(input logic [7:0] s, input int num_teams,
                                            input logic [7:0] la_sel, input logic [7:0] gpio_sel);
        tgt_sel_t r;
        r.kind = TGT_NONE;
        r.team = 8'h00;
        if (s != 8'h00 && int'(s) <= num_teams) begin
            r.kind = TGT_TEAM;
            r.team = s;
        end else if (s == la_sel) begin
            r.kind = TGT_LA;
        end else if (s == gpio_sel) begin
            r.kind = TGT_GPIO;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_xact_controller_if.sv
// rtl/wb_xact_controller_if.sv - Caravel Wishbone master-side bus seen by the transaction controller
interface wb_xact_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_target_mux.sv
// rtl/wb_target_mux.sv - selects ack and read data of the latched target from the flat target buses
module wb_target_mux
    import wb_xact_controller_pkg::*;
#(
    parameter int NUM_TEAMS = 1
) (
    input  tgt_sel_t                        sel,
    input  logic [32*(NUM_TEAMS+1)-1:0]     designs_dat,
    input  logic [NUM_TEAMS:0]              designs_ack,
    input  logic [31:0]                     la_dat,
    input  logic                            la_ack,
    input  logic [31:0]                     gpio_dat,
    input  logic                            gpio_ack,
    output logic                            ack,
    output logic [31:0]                     dat
);

    // Slot 0 is the reserved design index and is never selected.
    logic unused_slot0;
    assign unused_slot0 = ^{designs_dat[31:0], designs_ack[0]};

    always_comb begin
        ack = 1'b0;
        dat = 32'h0;
        case (sel.kind)
            TGT_TEAM: begin
                for (int i = 1; i <= NUM_TEAMS; i++) begin
                    if (sel.team == 8'(i)) begin
                        ack = designs_ack[i];
                        dat = designs_dat[i*32 +: 32];
                    end
                end
            end
            TGT_LA: begin
                ack = la_ack;
                dat = la_dat;
            end
            TGT_GPIO: begin
                ack = gpio_ack;
                dat = gpio_dat;
            end
            default: begin
                ack = 1'b0;
                dat = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/wb_xact_controller.sv
// rtl/wb_xact_controller.sv - registered single-outstanding Wishbone decode, strobe, timeout and response sequencer
module wb_xact_controller #(
    parameter int          NUM_TEAMS      = 1,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = wb_xact_controller_pkg::ERR_DATA,
    parameter logic [7:0]  LA_SEL         = wb_xact_controller_pkg::LA_SEL,
    parameter logic [7:0]  GPIO_SEL       = wb_xact_controller_pkg::GPIO_SEL
) (
    input  logic                            wb_clk_i,
    input  logic                            nrst,
    wb_xact_if.slave                        wb,
    output logic [NUM_TEAMS:0]              designs_stb,
    output logic                            la_control_stb,
    output logic                            gpio_control_stb,
    output logic [31:0]                     adr_truncated,
    input  logic [32*(NUM_TEAMS+1)-1:0]     designs_wbs_dat_o_flat,
    input  logic [31:0]                     la_control_dat_o,
    input  logic [31:0]                     gpio_control_dat_o,
    input  logic [NUM_TEAMS:0]              designs_ack_o,
    input  logic                            la_control_ack_o,
    input  logic                            gpio_control_ack_o,
    input  logic                            clear_timeout,
    output logic                            timeout_flag,
    output logic [7:0]                      timeout_target
);
    import wb_xact_controller_pkg::*;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    tgt_sel_t    sel;
    logic [7:0]  sel_s;
    logic [15:0] counter;

    tgt_sel_t           dec_sel;
    logic [NUM_TEAMS:0] dec_onehot;
    logic               mux_ack;
    logic [31:0]        mux_dat;

    // Write enable and the upper address byte play no part in sequencing.
    logic unused_bits;
    assign unused_bits = ^{wb.wbs_we_i, wb.wbs_adr_i[31:24]};

    always_comb begin
        dec_sel    = decode_sel(wb.wbs_adr_i[23:16], NUM_TEAMS, LA_SEL, GPIO_SEL);
        dec_onehot = '0;
        for (int i = 1; i <= NUM_TEAMS; i++) begin
            if (dec_sel.kind == TGT_TEAM && dec_sel.team == 8'(i)) begin
                dec_onehot[i] = 1'b1;
            end
        end
    end

    wb_target_mux #(.NUM_TEAMS(NUM_TEAMS)) u_mux (
        .sel         (sel),
        .designs_dat (designs_wbs_dat_o_flat),
        .designs_ack (designs_ack_o),
        .la_dat      (la_control_dat_o),
        .la_ack      (la_control_ack_o),
        .gpio_dat    (gpio_control_dat_o),
        .gpio_ack    (gpio_control_ack_o),
        .ack         (mux_ack),
        .dat         (mux_dat)
    );

    always_ff @(posedge wb_clk_i or negedge nrst) begin
        if (!nrst) begin
            state            <= ST_IDLE;
            sel              <= '{kind: TGT_NONE, team: 8'h00};
            sel_s            <= 8'h00;
            counter          <= 16'h0;
            designs_stb      <= '0;
            la_control_stb   <= 1'b0;
            gpio_control_stb <= 1'b0;
            adr_truncated    <= 32'h0;
            wb.wbs_ack_o     <= 1'b0;
            wb.wbs_dat_o     <= 32'h0;
            timeout_flag     <= 1'b0;
            timeout_target   <= 8'h00;
        end else begin
            if (clear_timeout) begin
                timeout_flag   <= 1'b0;
                timeout_target <= 8'h00;
            end
            case (state)
                ST_IDLE: begin
                    if (wb.wbs_cyc_i && wb.wbs_stb_i) begin
                        sel           <= dec_sel;
                        sel_s         <= wb.wbs_adr_i[23:16];
                        adr_truncated <= {16'h0, wb.wbs_adr_i[15:0]};
                        counter       <= 16'h0;
                        if (dec_sel.kind == TGT_NONE) begin
                            wb.wbs_ack_o <= 1'b1;
                            wb.wbs_dat_o <= ERR_DATA;
                            state        <= ST_RESP;
                        end else begin
                            designs_stb      <= dec_onehot;
                            la_control_stb   <= (dec_sel.kind == TGT_LA);
                            gpio_control_stb <= (dec_sel.kind == TGT_GPIO);
                            state            <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (!wb.wbs_cyc_i) begin
                        designs_stb      <= '0;
                        la_control_stb   <= 1'b0;
                        gpio_control_stb <= 1'b0;
                        state            <= ST_IDLE;
                    end else if (mux_ack) begin
                        designs_stb      <= '0;
                        la_control_stb   <= 1'b0;
                        gpio_control_stb <= 1'b0;
                        wb.wbs_ack_o     <= 1'b1;
                        wb.wbs_dat_o     <= mux_dat;
                        state            <= ST_RESP;
                    end else if (counter == TIMEOUT_LAST) begin
                        designs_stb      <= '0;
                        la_control_stb   <= 1'b0;
                        gpio_control_stb <= 1'b0;
                        wb.wbs_ack_o     <= 1'b1;
                        wb.wbs_dat_o     <= ERR_DATA;
                        state            <= ST_RESP;
                        // A timeout landing on a clear re-arms with this transaction.
                        if (!timeout_flag || clear_timeout) begin
                            timeout_flag   <= 1'b1;
                            timeout_target <= sel_s;
                        end
                    end else begin
                        counter <= counter + 16'h1;
                    end
                end
                ST_RESP: begin
                    wb.wbs_ack_o <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
